// File: rtl/ila_probe_capture_if.sv
// rtl/ila_probe_capture_if.sv - probe, trigger, readback and status bundle of the probe capture block
interface ila_probe_capture_if #(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]    probe0;
    logic [3:0]    probe1;
    logic          probe6;
    logic          probe7;
    logic          arm;
    logic [10:0]   trig_mask;
    logic [10:0]   trig_value;
    logic [AW-1:0] rd_addr;
    logic [10:0]   rd_data;
    logic          armed;
    logic          triggered;
    logic          done;
    logic [AW-1:0] trig_index;

    modport master (
        output probe0, probe1, probe6, probe7, arm, trig_mask, trig_value, rd_addr,
        input  rd_data, armed, triggered, done, trig_index
    );

    modport slave (
        input  probe0, probe1, probe6, probe7, arm, trig_mask, trig_value, rd_addr,
        output rd_data, armed, triggered, done, trig_index
    );
endinterface

// File: rtl/ila_probe_capture.sv
// rtl/ila_probe_capture.sv - triggered probe capture buffer with pre-trigger history and readback
module ila_probe_capture #(
    parameter int DEPTH       = 64,
    parameter int PRE_SAMPLES = 16
) (
    input logic             clk,
    input logic             reset,
    ila_probe_capture_if.slave bus
);
    localparam int AW     = $clog2(DEPTH);
    localparam int POST_N = DEPTH - PRE_SAMPLES - 1;

    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_SAMPLES - 1);
    localparam logic [AW-1:0] PRE_OFF   = AW'(PRE_SAMPLES);
    localparam logic [AW-1:0] POST_LAST = AW'((POST_N > 0) ? POST_N - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] pre_cnt;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] trig_index_q;
    logic [AW-1:0] rd_ptr;
    logic [10:0]   sample;
    logic [10:0]   rd_q;
    logic          trig_hit;
    logic          triggered_q;
    logic          wr_en;
    logic          start;

    assign sample   = {bus.probe7, bus.probe6, bus.probe1, bus.probe0};
    assign trig_hit = ((sample ^ bus.trig_value) & bus.trig_mask) == 11'd0;

    // Oldest kept sample sits PRE_SAMPLES slots before the trigger; wraps naturally in AW bits.
    assign rd_ptr = trig_index_q - PRE_OFF + bus.rd_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle write/start decisions.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        start      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.arm) begin
                    state_next = S_PRE;
                    start      = 1'b1;
                end
            end
            S_PRE: begin
                wr_en = 1'b1;
                if (pre_cnt == PRE_LAST) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                wr_en = 1'b1;
                if (trig_hit) begin
                    // With no post samples left the trigger write is the last one.
                    state_next = (POST_N == 0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                wr_en = 1'b1;
                if (post_cnt == POST_LAST) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Write pointer, phase counters and trigger bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp           <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            trig_index_q <= '0;
            triggered_q  <= 1'b0;
        end else begin
            if (start) begin
                wp          <= '0;
                pre_cnt     <= '0;
                post_cnt    <= '0;
                triggered_q <= 1'b0;
            end
            if (wr_en) begin
                wp <= wp + 1'b1;
            end
            if (state == S_PRE) begin
                pre_cnt <= pre_cnt + 1'b1;
            end
            if (state == S_POST) begin
                post_cnt <= post_cnt + 1'b1;
            end
            if (state == S_WAIT && trig_hit) begin
                trig_index_q <= wp;
                triggered_q  <= 1'b1;
            end
        end
    end

    // Capture memory; never cleared, only written while a capture is running.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wp] <= sample;
        end
    end

    // Registered readback; held at zero until the first arm so unwritten memory is never shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
        end else if (state != S_IDLE) begin
            rd_q <= mem[rd_ptr];
        end
    end

    assign bus.rd_data    = rd_q;
    assign bus.armed      = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign bus.triggered  = triggered_q;
    assign bus.done       = (state == S_DONE);
    assign bus.trig_index = trig_index_q;
endmodule

// File: tb/tb_ila_probe_capture.sv
// tb/tb_ila_probe_capture.sv - randomized self-checking bench for ila_probe_capture
module tb_ila_probe_capture;
    localparam int DEPTH  = 64;
    localparam int PRE    = 16;
    localparam int POST_N = DEPTH - PRE - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ila_probe_capture_if #(.DEPTH(DEPTH)) bus ();

    ila_probe_capture #(
        .DEPTH      (DEPTH),
        .PRE_SAMPLES(PRE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [10:0] hist[$];
    logic [10:0] rb[DEPTH];
    logic [10:0] mask;
    logic [10:0] value;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Position (in write order since arm) of the first sample eligible to trigger, or -1.
    function automatic int find_trig();
        for (int k = PRE; k < hist.size(); k++) begin
            if ((hist[k] & mask) == (value & mask)) return k;
        end
        return -1;
    endfunction

    function automatic logic [10:0] gen(input int mode, input int c, input logic [4:0] off);
        logic [10:0] r;
        logic [4:0]  lo;
        r  = 11'($urandom);
        lo = c[4:0] + off;
        case (mode)
            0:       return {6'd0, c[4:0]};
            1:       return {r[10:5], lo};
            2:       return {1'((c < PRE) || (c >= PRE + 200)), r[9:0]};
            default: return r;
        endcase
    endfunction

    task automatic drive_sample(input logic [10:0] s);
        bus.probe0 = s[4:0];
        bus.probe1 = s[8:5];
        bus.probe6 = s[9];
        bus.probe7 = s[10];
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_armed"}, 32'(bus.armed), 32'd0);
        check_eq({tag, "_triggered"}, 32'(bus.triggered), 32'd0);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_trig_index"}, 32'(bus.trig_index), 32'd0);
        check_eq({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
    endtask

    task automatic run_capture(input int mode, input int budget, output bit completed);
        int          t;
        int          n;
        bit          exp_done;
        bit          exp_trg;
        logic [4:0]  off;
        off = 5'($urandom);
        exp_done = 1'b0;
        bus.arm = 1'b1;
        drive_sample(11'($urandom));
        @(posedge clk);
        #1;
        bus.arm = 1'b0;
        hist.delete();
        check_eq("arm_armed", 32'(bus.armed), 32'd1);
        check_eq("arm_triggered", 32'(bus.triggered), 32'd0);
        check_eq("arm_done", 32'(bus.done), 32'd0);
        for (int c = 0; c < budget; c++) begin
            logic [10:0] s;
            s = gen(mode, c, off);
            drive_sample(s);
            bus.arm = ($urandom_range(0, 7) == 0);
            bus.rd_addr = 6'($urandom);
            hist.push_back(s);
            @(posedge clk);
            #1;
            t = find_trig();
            n = hist.size();
            exp_trg  = (t >= 0) && (n >= t + 1);
            exp_done = (t >= 0) && (n >= t + 1 + POST_N);
            check_eq("cap_armed", 32'(bus.armed), 32'(!exp_done));
            check_eq("cap_triggered", 32'(bus.triggered), 32'(exp_trg));
            check_eq("cap_done", 32'(bus.done), 32'(exp_done));
            if (exp_done) break;
        end
        bus.arm = 1'b0;
        completed = exp_done;
    endtask

    task automatic readback(input int mode);
        int t;
        t = find_trig();
        check_eq("trig_index", 32'(bus.trig_index), 32'(t % DEPTH));
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_addr = 6'(a);
            drive_sample(11'($urandom));
            @(posedge clk);
            #1;
            rb[a] = bus.rd_data;
            check_eq($sformatf("rd_%0d", a), 32'(bus.rd_data), 32'(hist[t - PRE + a]));
        end
        check_eq("done_held", 32'(bus.done), 32'd1);
        if (mode == 0) begin
            check_eq("cnt_trig_pos", 32'(bus.trig_index), 32'd16);
            check_eq("cnt_rd16", 32'(rb[16][4:0]), 32'd16);
        end
        if (mode == 1) begin
            check_eq("ramp_rd16", 32'(rb[16][4:0]), 32'h13);
            check_eq("ramp_rd15", 32'(rb[15][4:0]), 32'h12);
            check_eq("ramp_rd17", 32'(rb[17][4:0]), 32'h14);
        end
        if (mode == 2) begin
            check_eq("p7_rd16", 32'(rb[16][10]), 32'd1);
            for (int a = 0; a < PRE; a++) begin
                check_eq($sformatf("p7_pre_%0d", a), 32'(rb[a][10]), 32'd0);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit ok;
        reset          = 1'b1;
        bus.arm        = 1'b0;
        bus.rd_addr    = '0;
        bus.trig_mask  = '0;
        bus.trig_value = '0;
        drive_sample('0);
        mask  = '0;
        value = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset with moving probes and read address.
        for (int c = 0; c < 100; c++) begin
            drive_sample(11'($urandom));
            bus.rd_addr = 6'($urandom);
            @(posedge clk);
            #1;
        end
        check_idle("idle");

        // Free-running trigger: first WAIT sample fires.
        mask = 11'h000; value = 11'($urandom);
        bus.trig_mask = mask; bus.trig_value = value;
        run_capture(0, 200, ok);
        check_eq("cnt_complete", 32'(ok), 32'd1);
        if (ok) readback(0);

        // Ramp on probe0 with a 5-bit compare.
        mask = 11'h01F; value = 11'h013;
        bus.trig_mask = mask; bus.trig_value = value;
        run_capture(1, 200, ok);
        check_eq("ramp_complete", 32'(ok), 32'd1);
        if (ok) readback(1);

        // probe7 high only in PRE, low for 200 WAIT cycles, then high.
        mask = 11'h400; value = 11'h400;
        bus.trig_mask = mask; bus.trig_value = value;
        run_capture(2, 400, ok);
        check_eq("p7_complete", 32'(ok), 32'd1);
        if (ok) readback(2);

        // Abort in POST with arm and reset together, then a fresh capture.
        mask = 11'h000; value = '0;
        bus.trig_mask = mask; bus.trig_value = value;
        run_capture(0, 30, ok);
        check_eq("abort_incomplete", 32'(ok), 32'd0);
        check_eq("abort_in_post", 32'(bus.triggered), 32'd1);
        bus.arm = 1'b1;
        do_reset();
        bus.arm = 1'b0;
        check_idle("abort");
        @(posedge clk);
        #1;
        check_eq("abort_stay_idle", 32'(bus.armed), 32'd0);

        // Random re-arms from DONE with sparse masks.
        for (int i = 0; i < 5; i++) begin
            mask  = 11'(1 << $urandom_range(0, 10)) | 11'(1 << $urandom_range(0, 10));
            value = 11'($urandom);
            bus.trig_mask = mask; bus.trig_value = value;
            run_capture(3, 1000, ok);
            if (ok) begin
                readback(3);
            end else begin
                do_reset();
                check_idle("rnd_reset");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
